// File: rtl/midi_voice_allocator.sv
// rtl/midi_voice_allocator.sv - polyphonic voice allocator with free-first, oldest-steal policy
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  msg_valid_i,
    input  logic [1:0]                            msg_len_i,
    input  logic [7:0]                            msg_status_i,
    input  logic [7:0]                            msg_data1_i,
    input  logic [7:0]                            msg_data2_i,
    output logic [NUM_VOICES-1:0]                 voice_gate_o,
    output logic [NUM_VOICES-1:0]                 voice_trig_o,
    output logic [7*NUM_VOICES-1:0]               voice_note_o,
    output logic [7*NUM_VOICES-1:0]               voice_vel_o,
    output logic                                  steal_o,
    output logic [$clog2(NUM_VOICES+1)-1:0]       active_count_o
);

    localparam int RW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(NUM_VOICES + 1);

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];
    logic [6:0]            vel_d  [NUM_VOICES];
    logic [RW-1:0]         rank_q [NUM_VOICES];
    logic [RW-1:0]         rank_d [NUM_VOICES];
    logic                  steal_q, steal_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  is_on, is_off, is_all_off;
    logic                  hit, free;
    logic [RW-1:0]         hit_idx, free_idx, old_idx, tgt;
    logic [6:0]            msg_note, msg_vel;
    logic                  unused_msg_bits;

    assign msg_note        = msg_data1_i[6:0];
    assign msg_vel         = msg_data2_i[6:0];
    assign unused_msg_bits = ^{msg_data2_i[7], msg_status_i[3:0]};

    // Note-on with velocity 0 is the running-status idiom for note-off.
    always_comb begin
        is_on      = 1'b0;
        is_off     = 1'b0;
        is_all_off = 1'b0;
        if (msg_valid_i && msg_len_i == 2'd3) begin
            is_on      = (msg_status_i[7:4] == 4'h9) && (msg_vel != 7'd0);
            is_off     = (msg_status_i[7:4] == 4'h8) ||
                         ((msg_status_i[7:4] == 4'h9) && (msg_vel == 7'd0));
            is_all_off = (msg_status_i[7:4] == 4'hB) &&
                         ((msg_data1_i == 8'd120) || (msg_data1_i == 8'd123));
        end
    end

    // Scanning downward leaves the lowest matching index selected.
    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        old_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && note_q[i] == msg_note) begin
                hit     = 1'b1;
                hit_idx = RW'(i);
            end
            if (!gate_q[i]) begin
                free     = 1'b1;
                free_idx = RW'(i);
            end
            if (rank_q[i] == RW'(NUM_VOICES - 1)) begin
                old_idx = RW'(i);
            end
        end
        if (hit) begin
            tgt = hit_idx;
        end else if (free) begin
            tgt = free_idx;
        end else begin
            tgt = old_idx;
        end
    end

    always_comb begin
        gate_d  = gate_q;
        trig_d  = '0;
        steal_d = 1'b0;
        note_d  = note_q;
        vel_d   = vel_q;
        rank_d  = rank_q;
        if (is_on) begin
            gate_d[tgt] = 1'b1;
            trig_d[tgt] = 1'b1;
            note_d[tgt] = msg_note;
            vel_d[tgt]  = msg_vel;
            steal_d     = !hit && !free;
            // Move-to-front keeps ranks a permutation: only younger voices age.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (RW'(i) == tgt) begin
                    rank_d[i] = '0;
                end else if (rank_q[i] < rank_q[tgt]) begin
                    rank_d[i] = rank_q[i] + RW'(1);
                end
            end
        end else if (is_off) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (gate_q[i] && note_q[i] == msg_note) begin
                    gate_d[i] = 1'b0;
                end
            end
        end else if (is_all_off) begin
            gate_d = '0;
        end
        count_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_d = count_d + CW'(gate_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gate_q  <= '0;
            trig_q  <= '0;
            steal_q <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                rank_q[i] <= RW'(i);
            end
        end else begin
            gate_q  <= gate_d;
            trig_q  <= trig_d;
            steal_q <= steal_d;
            count_q <= count_d;
            note_q  <= note_d;
            vel_q   <= vel_d;
            rank_q  <= rank_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note_o[7*g +: 7] = note_q[g];
        assign voice_vel_o[7*g +: 7]  = vel_q[g];
    end

    assign voice_gate_o   = gate_q;
    assign voice_trig_o   = trig_q;
    assign steal_o        = steal_q;
    assign active_count_o = count_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb/tb_midi_voice_allocator.sv - randomized and directed check against an LRU timestamp model
module tb_midi_voice_allocator;

    localparam int NV = 4;
    localparam int CW = $clog2(NV + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            msg_valid = 1'b0;
    logic [1:0]      msg_len = '0;
    logic [7:0]      msg_status = '0;
    logic [7:0]      msg_data1 = '0;
    logic [7:0]      msg_data2 = '0;
    logic [NV-1:0]   voice_gate, voice_trig;
    logic [7*NV-1:0] voice_note, voice_vel;
    logic            steal;
    logic [CW-1:0]   active_count;

    int checks = 0;
    int errors = 0;

    midi_voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .msg_valid_i    (msg_valid),
        .msg_len_i      (msg_len),
        .msg_status_i   (msg_status),
        .msg_data1_i    (msg_data1),
        .msg_data2_i    (msg_data2),
        .voice_gate_o   (voice_gate),
        .voice_trig_o   (voice_trig),
        .voice_note_o   (voice_note),
        .voice_vel_o    (voice_vel),
        .steal_o        (steal),
        .active_count_o (active_count)
    );

    always #5 clk = ~clk;

    // Model: each voice remembers when it was last allocated; oldest stamp is stolen.
    bit       m_gate  [NV];
    bit [6:0] m_note  [NV];
    bit [6:0] m_vel   [NV];
    int       m_stamp [NV];
    int       m_tick;
    bit [NV-1:0] e_trig;
    bit          e_steal;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i]  = 1'b0;
            m_note[i]  = '0;
            m_vel[i]   = '0;
            m_stamp[i] = -i;
        end
        m_tick  = 1;
        e_trig  = '0;
        e_steal = 1'b0;
    endtask

    task automatic model_msg(input bit v, input bit [1:0] len, input bit [7:0] st,
                             input bit [7:0] d1, input bit [7:0] d2);
        bit on, off, alloff;
        int tgt;
        e_trig  = '0;
        e_steal = 1'b0;
        on      = v && len == 3 && st[7:4] == 4'h9 && d2[6:0] != 0;
        off     = v && len == 3 && (st[7:4] == 4'h8 || (st[7:4] == 4'h9 && d2[6:0] == 0));
        alloff  = v && len == 3 && st[7:4] == 4'hB && (d1 == 120 || d1 == 123);
        if (on) begin
            tgt = -1;
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_gate[i] && m_note[i] == d1[6:0]) tgt = i;
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_gate[i]) tgt = i;
            if (tgt < 0) begin
                tgt = 0;
                for (int i = 1; i < NV; i++)
                    if (m_stamp[i] < m_stamp[tgt]) tgt = i;
                e_steal = 1'b1;
            end
            m_gate[tgt]  = 1'b1;
            m_note[tgt]  = d1[6:0];
            m_vel[tgt]   = d2[6:0];
            m_stamp[tgt] = m_tick;
            m_tick++;
            e_trig[tgt]  = 1'b1;
        end else if (off) begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] && m_note[i] == d1[6:0]) m_gate[i] = 1'b0;
        end else if (alloff) begin
            for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NV-1:0]   g;
        logic [7*NV-1:0] n, vl;
        int              c;
        c = 0;
        for (int i = 0; i < NV; i++) begin
            g[i]         = m_gate[i];
            n[7*i +: 7]  = m_note[i];
            vl[7*i +: 7] = m_vel[i];
            c += int'(m_gate[i]);
        end
        check_eq({tag, ".gate"},  64'(voice_gate),   64'(g));
        check_eq({tag, ".trig"},  64'(voice_trig),   64'(e_trig));
        check_eq({tag, ".steal"}, 64'(steal),        64'(e_steal));
        check_eq({tag, ".count"}, 64'(active_count), 64'(c));
        check_eq({tag, ".note"},  64'(voice_note),   64'(n));
        check_eq({tag, ".vel"},   64'(voice_vel),    64'(vl));
    endtask

    task automatic send(input string tag, input bit v, input bit [1:0] len, input bit [7:0] st,
                        input bit [7:0] d1, input bit [7:0] d2);
        @(negedge clk);
        msg_valid  = v;
        msg_len    = len;
        msg_status = st;
        msg_data1  = d1;
        msg_data2  = d2;
        model_msg(v, len, st, d1, d2);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic on3(input string tag, input bit [7:0] n, input bit [7:0] v);
        send(tag, 1'b1, 2'd3, 8'h90, n, v);
    endtask

    task automatic idle();
        send("idle", 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    endtask

    int sel;
    bit [1:0] r_len;
    bit [7:0] r_st, r_d1, r_d2;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        on3("first_on", 60, 100);
        check_eq("first_on.gate_c", 64'(voice_gate), 64'h1);
        check_eq("first_on.note0_c", 64'(voice_note[6:0]), 64'd60);

        send("clr", 1'b1, 2'd3, 8'hB0, 8'd123, 8'd0);
        on3("alloc0", 60, 90);
        on3("alloc1", 62, 91);
        on3("alloc2", 64, 92);
        on3("alloc3", 65, 93);
        on3("steal", 67, 94);
        check_eq("steal.flag_c", 64'(steal), 64'h1);
        check_eq("steal.trig_c", 64'(voice_trig), 64'h1);
        check_eq("steal.gate_c", 64'(voice_gate), 64'hF);

        send("clr2", 1'b1, 2'd3, 8'hB0, 8'd120, 8'd0);
        on3("b0", 60, 10);
        on3("b1", 62, 11);
        on3("b2", 64, 12);
        on3("b3", 65, 13);
        send("off62", 1'b1, 2'd3, 8'h80, 8'd62, 8'd0);
        check_eq("off62.gate_c", 64'(voice_gate), 64'hD);
        check_eq("off62.note1_c", 64'(voice_note[13:7]), 64'd62);
        on3("refill", 70, 50);
        check_eq("refill.trig_c", 64'(voice_trig), 64'h2);

        send("clr3", 1'b1, 2'd3, 8'hB0, 8'd123, 8'd0);
        on3("rt_a", 60, 100);
        on3("rt_b", 60, 20);
        check_eq("rt_b.count_c", 64'(active_count), 64'd1);
        on3("rt_off", 60, 0);

        on3("c0", 40, 1);
        on3("c1", 41, 2);
        on3("c2", 42, 3);
        on3("c3", 43, 4);
        send("alloff", 1'b1, 2'd3, 8'hB0, 8'd123, 8'd0);
        check_eq("alloff.count_c", 64'(active_count), 64'd0);
        on3("d0", 44, 5);
        send("pgm", 1'b1, 2'd2, 8'hC0, 8'd5, 8'd0);
        send("cc7", 1'b1, 2'd3, 8'hB0, 8'd7, 8'd64);
        send("short_on", 1'b1, 2'd2, 8'h90, 8'd50, 8'd60);

        for (int k = 0; k < 400; k++) begin
            sel   = $urandom_range(0, 9);
            r_len = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd3;
            r_d1  = 8'($urandom_range(60, 67));
            r_d2  = 8'($urandom_range(0, 127));
            r_st  = 8'h90 | 8'($urandom_range(0, 15));
            case (sel)
                0, 1, 2, 3: r_d2 = 8'($urandom_range(1, 255));
                4: r_d2 = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00;
                5, 6: r_st = 8'h80 | 8'($urandom_range(0, 15));
                7: begin
                    r_st = 8'hB0;
                    r_d1 = ($urandom_range(0, 2) == 0) ? 8'd120 :
                           ($urandom_range(0, 1) != 0) ? 8'd123 : 8'd121;
                end
                8: r_st = 8'($urandom_range(0, 255));
                default: ;
            endcase
            if (k == 200) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                msg_valid = 1'b0;
                on3("post_rst", 61, 33);
                check_eq("post_rst.trig_c", 64'(voice_trig), 64'h1);
            end
            send("rand", (sel == 9) ? 1'b0 : 1'b1, r_len, r_st, r_d1, r_d2);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
